mem_responder_mc: RTL and testbench

- Multi-cycle memory responder: the slave end of the CPU's instruction/data memory interface.
- Accepts one read or write request at a time and holds the port busy for a fixed latency. It then returns the read data (or a write acknowledge) with a one-cycle valid pulse.
- Replaces the single-cycle memory model once the pipeline gains stall support.
- Used for both I-MEM and D-MEM instances.

---
 rtl/mem_responder_mc_pkg.sv | 20 ++
 rtl/mem_responder_mc_array.sv | 33 +++
 rtl/mem_responder_mc.sv | 132 +++++++++++++
 tb/tb_mem_responder_mc.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_responder_mc_pkg.sv
// Shared definitions for the multi-cycle memory responder.
// Holds the FSM state encoding, the memory word width and the response-type
// tags that the stall/hazard logic will also decode.
package mem_responder_mc_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   // Kind of response being produced: read data or a write acknowledge.
   typedef enum logic {
      RespRdData = 1'b0,
      RespWrAck  = 1'b1
   } resp_type_e;

endpackage

// File: rtl/mem_responder_mc_array.sv
// Single-port synchronous storage, 2^DEPTH_LOG2 words of WIDTH bits.
// Read-first: rdata_o returns the word stored at addr_i before any write
// performed at the same edge. Contents are not reset.
// Ports:
//   clk_i    - clock, rising edge
//   we_i     - write enable
//   addr_i   - word index
//   wdata_i  - write data
//   rdata_o  - registered read data
module mem_array_sp #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned WIDTH      = 16
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o
);

   logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder_mc.sv
// Multi-cycle memory responder (slave side of the CPU I-MEM / D-MEM port).
// Accepts one request at a time, stays busy for LATENCY-1 cycles, then
// presents the response with a one-cycle data_valid pulse.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - request strobe, accepted when busy=0
//   wr         - 1 = write, 0 = read (sampled on acceptance)
//   addr       - byte address, addr[0] ignored (sampled on acceptance)
//   data_in    - write data (sampled on acceptance)
//   busy       - request in flight, new requests ignored
//   data_valid - one-cycle response pulse
//   data_out   - read data or echoed write data, held until next response
module mem_responder_mc
   import mem_responder_mc_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_W-1:0]     data_in,
   output logic                  busy,
   output logic                  data_valid,
   output logic [WORD_W-1:0]     data_out
);

   if (LATENCY < 2 || LATENCY > 15) begin : gen_bad_latency
      $error("mem_responder_mc: LATENCY must be in 2..15");
   end
   if (ADDR_WIDTH < DEPTH_LOG2 + 2) begin : gen_bad_addr
      $error("mem_responder_mc: ADDR_WIDTH must exceed DEPTH_LOG2 + 1");
   end

   localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   resp_type_e              rtype_q, rtype_d;
   logic [WORD_W-1:0]       wdata_q, wdata_d;
   logic [WORD_W-1:0]       dout_q, dout_d;

   logic                    mem_we;
   logic [DEPTH_LOG2-1:0]   mem_addr;
   logic [WORD_W-1:0]       mem_rdata;
   logic [DEPTH_LOG2-1:0]   in_idx;
   logic                    unused_addr_bits;

   // Bits above the word index alias, and addr[0] selects a byte we never use.
   assign in_idx           = addr[DEPTH_LOG2:1];
   assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:DEPTH_LOG2+1], addr[0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      rtype_d  = rtype_q;
      wdata_d  = wdata_q;
      dout_d   = dout_q;
      mem_we   = 1'b0;
      // While waiting, the array is re-read at the captured index every edge so
      // the word is ready in mem_rdata by the edge that enters RESP.
      mem_addr = idx_q;

      unique case (state_q)
         StIdle, StResp: begin
            if (enable) begin
               state_d  = StWait;
               cnt_d    = CntLoad;
               idx_d    = in_idx;
               rtype_d  = wr ? RespWrAck : RespRdData;
               wdata_d  = data_in;
               mem_addr = in_idx;
               // Writes commit at the acceptance edge.
               mem_we   = wr;
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (cnt_q == 4'd1) begin
               state_d = StResp;
               dout_d  = (rtype_q == RespWrAck) ? wdata_q : mem_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         rtype_q <= RespRdData;
         wdata_q <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rtype_q <= rtype_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
      end
   end

   mem_array_sp #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (WORD_W)
   ) u_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (data_in),
      .rdata_o (mem_rdata)
   );

   assign busy       = (state_q == StWait);
   assign data_valid = (state_q == StResp);
   assign data_out   = dout_q;

endmodule

// File: tb/tb_mem_responder_mc.sv
// Directed self-checking bench for mem_responder_mc with LATENCY=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_responder_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        busy;
   logic        data_valid;
   logic [15:0] data_out;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mem_responder_mc #(
      .ADDR_WIDTH (16),
      .DEPTH_LOG2 (12),
      .LATENCY    (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .wr         (wr),
      .addr       (addr),
      .data_in    (data_in),
      .busy       (busy),
      .data_valid (data_valid),
      .data_out   (data_out)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Called on a falling edge; request is accepted at the next rising edge.
   // Returns on the falling edge of the first WAIT cycle.
   task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d);
      enable  = 1'b1;
      wr      = w;
      addr    = a;
      data_in = d;
      @(negedge clk);
      enable  = 1'b0;
   endtask

   // From the first WAIT cycle: three busy cycles, then the response cycle.
   // Returns on the falling edge of the response cycle.
   task automatic expect_resp(input string tag, input logic [15:0] exp);
      for (int k = 1; k <= 3; k++) begin
         chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
         chk({tag, "_novalid"}, {15'd0, data_valid}, 16'd0);
         @(negedge clk);
      end
      chk({tag, "_valid"}, {15'd0, data_valid}, 16'd1);
      chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
      chk({tag, "_data"}, data_out, exp);
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b0;
      wr      = 1'b0;
      addr    = 16'h0000;
      data_in = 16'h0000;

      // Reset and idle
      repeat (2) @(negedge clk);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_valid", {15'd0, data_valid}, 16'd0);
      chk("rst_dout", data_out, 16'h0000);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle_valid", {15'd0, data_valid}, 16'd0);
         chk("idle_busy", {15'd0, busy}, 16'd0);
      end

      // Write then read
      start(1'b1, 16'h0010, 16'hBEEF);
      expect_resp("wr10", 16'hBEEF);
      @(negedge clk);
      chk("after_valid", {15'd0, data_valid}, 16'd0);
      chk("hold_dout", data_out, 16'hBEEF);
      start(1'b0, 16'h0010, 16'h0000);
      expect_resp("rd10", 16'hBEEF);
      @(negedge clk);

      // Load word 9 (byte 0x0012) for the back-to-back test
      start(1'b1, 16'h0012, 16'h1234);
      expect_resp("wr12", 16'h1234);
      @(negedge clk);

      // Back-to-back: second request accepted in the RESP cycle
      start(1'b0, 16'h0010, 16'h0000);
      expect_resp("b2b1", 16'hBEEF);
      start(1'b0, 16'h0012, 16'h0000);
      expect_resp("b2b2", 16'h1234);
      @(negedge clk);
      chk("b2b_end_valid", {15'd0, data_valid}, 16'd0);
      chk("b2b_end_busy", {15'd0, busy}, 16'd0);

      // Request while busy is ignored
      start(1'b0, 16'h0010, 16'h0000);
      enable  = 1'b1;
      wr      = 1'b1;
      addr    = 16'h0010;
      data_in = 16'h0000;
      chk("ign_busy1", {15'd0, busy}, 16'd1);
      @(negedge clk);
      chk("ign_busy2", {15'd0, busy}, 16'd1);
      @(negedge clk);
      enable = 1'b0;
      chk("ign_busy3", {15'd0, busy}, 16'd1);
      @(negedge clk);
      chk("ign_valid", {15'd0, data_valid}, 16'd1);
      chk("ign_data", data_out, 16'hBEEF);
      @(negedge clk);
      start(1'b0, 16'h0010, 16'h0000);
      expect_resp("ign_reread", 16'hBEEF);
      @(negedge clk);

      // Aliasing: 0x2004 and 0x0005 both map to word 2
      start(1'b1, 16'h2004, 16'hA5A5);
      expect_resp("alias_wr", 16'hA5A5);
      @(negedge clk);
      start(1'b0, 16'h0005, 16'h0000);
      expect_resp("alias_rd", 16'hA5A5);
      @(negedge clk);

      // Reset in the 2nd WAIT cycle
      start(1'b1, 16'h0020, 16'h5555);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {15'd0, busy}, 16'd0);
      chk("mid_rst_valid", {15'd0, data_valid}, 16'd0);
      chk("mid_rst_dout", data_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_valid", {15'd0, data_valid}, 16'd0);
      end
      start(1'b0, 16'h0020, 16'h0000);
      expect_resp("post_rst_rd", 16'h5555);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
